// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Shared widths, constants and FIFO entry type for the
//               register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int FWD_PORT1 = 0;
  localparam int FWD_PORT2 = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } md_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_fifo.sv
// ============================================================================
// Module      : md_result_fifo
// Description : Synchronous FIFO holding mult/div results awaiting the
//               register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_result_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  md_entry_t                  i_data,
  output md_entry_t                  o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  md_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file write port between WB and the
//               mult/div unit; tracks pending MD results and ID bypasses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWrite_WB,
  input  logic [REG_ADDR_W-1:0] Write_Register_WB,
  input  logic [REG_DATA_W-1:0] Write_Data_WB,
  input  logic                  MD_Issue,
  input  logic [REG_ADDR_W-1:0] MD_Issue_Register,
  input  logic                  MD_Valid,
  input  logic [REG_ADDR_W-1:0] MD_Register,
  input  logic [REG_DATA_W-1:0] MD_Data,
  output logic                  MD_Ready,
  input  logic [REG_ADDR_W-1:0] Read_Address_1_ID,
  input  logic [REG_ADDR_W-1:0] Read_Address_2_ID,
  output logic                  RegWrite_Port,
  output logic [REG_ADDR_W-1:0] Write_Register_Port,
  output logic [REG_DATA_W-1:0] Write_Data_Port,
  output logic [1:0]            Forward_Reg_Delay,
  output logic                  Stall_ID,
  output logic                  Drain_Req
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic                       w_wb_active;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_issue;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  md_entry_t                  w_head;
  md_entry_t                  w_md_entry;
  logic [31:0]                w_pending_next;
  logic [31:0]                r_pending;
  logic [CNT_W-1:0]           r_starve;

  assign w_wb_active = RegWrite_WB & (Write_Register_WB != REG_ZERO);
  assign w_issue     = MD_Issue & (MD_Issue_Register != REG_ZERO);
  assign MD_Ready    = ~w_full;
  assign w_push      = MD_Valid & MD_Ready;
  assign w_pop       = ~Reset & ~w_wb_active & ~w_empty;
  assign w_md_entry  = '{addr: MD_Register, data: MD_Data};

  md_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_md_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    RegWrite_Port       = 1'b0;
    Write_Register_Port = REG_ZERO;
    Write_Data_Port     = '0;
    if (w_wb_active) begin
      RegWrite_Port       = ~Reset;
      Write_Register_Port = Write_Register_WB;
      Write_Data_Port     = Write_Data_WB;
    end else if (!w_empty) begin
      RegWrite_Port       = ~Reset;
      Write_Register_Port = w_head.addr;
      Write_Data_Port     = w_head.data;
    end
  end

  // A new issue overrides a retiring result for the same register.
  always_comb begin
    w_pending_next = r_pending;
    if (w_pop)   w_pending_next[w_head.addr]       = 1'b0;
    if (w_issue) w_pending_next[MD_Issue_Register] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pending <= '0;
      r_starve  <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_empty || w_pop) r_starve <= '0;
      else if (r_starve != C_STARVE_MAX) r_starve <= r_starve + 1'b1;
    end
  end

  assign Stall_ID  = r_pending[Read_Address_1_ID] | r_pending[Read_Address_2_ID];
  assign Drain_Req = (r_starve == C_STARVE_MAX);

  assign Forward_Reg_Delay[FWD_PORT1] = RegWrite_Port & (Write_Register_Port == Read_Address_1_ID)
                                        & (Read_Address_1_ID != REG_ZERO);
  assign Forward_Reg_Delay[FWD_PORT2] = RegWrite_Port & (Write_Register_Port == Read_Address_2_ID)
                                        & (Read_Address_2_ID != REG_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWrite_WB;
  logic [4:0]  Write_Register_WB;
  logic [31:0] Write_Data_WB;
  logic        MD_Issue;
  logic [4:0]  MD_Issue_Register;
  logic        MD_Valid;
  logic [4:0]  MD_Register;
  logic [31:0] MD_Data;
  logic        MD_Ready;
  logic [4:0]  Read_Address_1_ID;
  logic [4:0]  Read_Address_2_ID;
  logic        RegWrite_Port;
  logic [4:0]  Write_Register_Port;
  logic [31:0] Write_Data_Port;
  logic [1:0]  Forward_Reg_Delay;
  logic        Stall_ID;
  logic        Drain_Req;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (8)
  ) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .RegWrite_WB         (RegWrite_WB),
    .Write_Register_WB   (Write_Register_WB),
    .Write_Data_WB       (Write_Data_WB),
    .MD_Issue            (MD_Issue),
    .MD_Issue_Register   (MD_Issue_Register),
    .MD_Valid            (MD_Valid),
    .MD_Register         (MD_Register),
    .MD_Data             (MD_Data),
    .MD_Ready            (MD_Ready),
    .Read_Address_1_ID   (Read_Address_1_ID),
    .Read_Address_2_ID   (Read_Address_2_ID),
    .RegWrite_Port       (RegWrite_Port),
    .Write_Register_Port (Write_Register_Port),
    .Write_Data_Port     (Write_Data_Port),
    .Forward_Reg_Delay   (Forward_Reg_Delay),
    .Stall_ID            (Stall_ID),
    .Drain_Req           (Drain_Req)
  );

  always #5 Clk = ~Clk;

  // Inputs change 1ns after the edge; outputs are sampled 1ns later still.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    RegWrite_WB = 0; Write_Register_WB = 0; Write_Data_WB = 0;
    MD_Issue = 0; MD_Issue_Register = 0;
    MD_Valid = 0; MD_Register = 0; MD_Data = 0;
    Read_Address_1_ID = 0; Read_Address_2_ID = 0;
  endtask

  task automatic test_reset();
    idle(); Reset = 1; step(); step();
    Reset = 0; settle();
    checks++; if (MD_Ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b want 1", MD_Ready); end
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite_Port); end
    checks++; if (Stall_ID !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_ID); end
    checks++; if (Drain_Req !== 1'b0) begin errors++; $display("FAIL reset_drain: got %b want 0", Drain_Req); end
    checks++; if (Forward_Reg_Delay !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b want 00", Forward_Reg_Delay); end
    // Queue two results behind WB, then reset mid-burst.
    step();
    RegWrite_WB = 1; Write_Register_WB = 8; Write_Data_WB = 32'h8;
    MD_Valid = 1; MD_Register = 1; MD_Data = 32'h11; step();
    MD_Register = 2; MD_Data = 32'h22; step();
    MD_Valid = 0; settle();
    checks++; if (MD_Ready !== 1'b0) begin errors++; $display("FAIL burst_full: got %b want 0", MD_Ready); end
    idle(); Reset = 1; settle();
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL reset_forces_no_write: got %b want 0", RegWrite_Port); end
    step(); Reset = 0; settle();
    checks++; if (dut.u_fifo.o_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.o_count); end
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL post_reset_no_write: got %b want 0", RegWrite_Port); end
    checks++; if (MD_Ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", MD_Ready); end
  endtask

  task automatic test_md_basic();
    idle(); Read_Address_1_ID = 5;
    MD_Issue = 1; MD_Issue_Register = 5; step();
    MD_Issue = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL md_wait_stall[%0d]: got %b want 1", i, Stall_ID); end
      step();
    end
    MD_Valid = 1; MD_Register = 5; MD_Data = 32'h1234; settle();
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL md_no_early_write: got %b want 0", RegWrite_Port); end
    step(); MD_Valid = 0; settle();
    checks++; if (RegWrite_Port !== 1'b1) begin errors++; $display("FAIL md_write_en: got %b want 1", RegWrite_Port); end
    checks++; if (Write_Register_Port !== 5'd5) begin errors++; $display("FAIL md_write_addr: got %0d want 5", Write_Register_Port); end
    checks++; if (Write_Data_Port !== 32'h1234) begin errors++; $display("FAIL md_write_data: got %h want 00001234", Write_Data_Port); end
    checks++; if (Forward_Reg_Delay !== 2'b01) begin errors++; $display("FAIL md_fwd: got %b want 01", Forward_Reg_Delay); end
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL md_pop_cycle_stall: got %b want 1", Stall_ID); end
    step();
    checks++; if (Stall_ID !== 1'b0) begin errors++; $display("FAIL md_stall_clear: got %b want 0", Stall_ID); end
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL md_port_idle: got %b want 0", RegWrite_Port); end
  endtask

  task automatic test_starve();
    idle();
    RegWrite_WB = 1; Write_Register_WB = 8; Write_Data_WB = 32'h88;
    MD_Valid = 1; MD_Register = 9; MD_Data = 32'h99; settle();
    checks++; if (Write_Register_Port !== 5'd8) begin errors++; $display("FAIL starve_wb_owns: got %0d want 8", Write_Register_Port); end
    step();
    MD_Register = 10; MD_Data = 32'hA0; settle();
    checks++; if (MD_Ready !== 1'b1) begin errors++; $display("FAIL starve_ready_one: got %b want 1", MD_Ready); end
    step();
    MD_Valid = 0;
    // One non-pop edge already counted; seven more reach the limit.
    for (int i = 0; i < 7; i++) begin
      settle();
      checks++; if (Drain_Req !== 1'b0) begin errors++; $display("FAIL starve_early_drain[%0d]: got %b want 0", i, Drain_Req); end
      step();
    end
    settle();
    checks++; if (MD_Ready !== 1'b0) begin errors++; $display("FAIL starve_full: got %b want 0", MD_Ready); end
    checks++; if (Drain_Req !== 1'b1) begin errors++; $display("FAIL starve_drain: got %b want 1", Drain_Req); end
    RegWrite_WB = 0; settle();
    checks++; if (Write_Register_Port !== 5'd9 || Write_Data_Port !== 32'h99)
      begin errors++; $display("FAIL starve_pop_r9: got r%0d=%h want r9=00000099", Write_Register_Port, Write_Data_Port); end
    checks++; if (Drain_Req !== 1'b1) begin errors++; $display("FAIL starve_drain_hold: got %b want 1", Drain_Req); end
    step();
    checks++; if (Drain_Req !== 1'b0) begin errors++; $display("FAIL starve_drain_fall: got %b want 0", Drain_Req); end
    checks++; if (RegWrite_Port !== 1'b1 || Write_Register_Port !== 5'd10 || Write_Data_Port !== 32'hA0)
      begin errors++; $display("FAIL starve_pop_r10: got en=%b r%0d=%h want en=1 r10=000000a0", RegWrite_Port, Write_Register_Port, Write_Data_Port); end
    step();
    checks++; if (RegWrite_Port !== 1'b0) begin errors++; $display("FAIL starve_empty: got %b want 0", RegWrite_Port); end
  endtask

  task automatic test_wb_r0();
    idle();
    RegWrite_WB = 1; Write_Register_WB = 8; Write_Data_WB = 32'h8;
    MD_Valid = 1; MD_Register = 3; MD_Data = 32'hBEEF; step();
    MD_Valid = 0; Write_Register_WB = 0; Write_Data_WB = 32'hDEAD; settle();
    checks++; if (RegWrite_Port !== 1'b1 || Write_Register_Port !== 5'd3 || Write_Data_Port !== 32'hBEEF)
      begin errors++; $display("FAIL wb_r0_pop: got en=%b r%0d=%h want en=1 r3=0000beef", RegWrite_Port, Write_Register_Port, Write_Data_Port); end
    step();
    checks++; if (RegWrite_Port !== 1'b0 || Write_Data_Port !== 32'h0)
      begin errors++; $display("FAIL wb_r0_idle: got en=%b data=%h want en=0 data=0", RegWrite_Port, Write_Data_Port); end
  endtask

  task automatic test_forward();
    idle();
    RegWrite_WB = 1; Write_Register_WB = 7; Write_Data_WB = 32'h77;
    Read_Address_1_ID = 7; Read_Address_2_ID = 7; settle();
    checks++; if (Forward_Reg_Delay !== 2'b11) begin errors++; $display("FAIL fwd_both: got %b want 11", Forward_Reg_Delay); end
    Read_Address_2_ID = 3; settle();
    checks++; if (Forward_Reg_Delay !== 2'b01) begin errors++; $display("FAIL fwd_port1: got %b want 01", Forward_Reg_Delay); end
    Read_Address_1_ID = 3; Read_Address_2_ID = 7; settle();
    checks++; if (Forward_Reg_Delay !== 2'b10) begin errors++; $display("FAIL fwd_port2: got %b want 10", Forward_Reg_Delay); end
    Write_Register_WB = 0; Read_Address_1_ID = 0; Read_Address_2_ID = 0; settle();
    checks++; if (Forward_Reg_Delay !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b want 00", Forward_Reg_Delay); end
    step();
  endtask

  task automatic test_set_wins();
    idle();
    MD_Valid = 1; MD_Register = 4; MD_Data = 32'h44; step();
    MD_Valid = 0; MD_Issue = 1; MD_Issue_Register = 4; Read_Address_1_ID = 4; settle();
    checks++; if (Write_Register_Port !== 5'd4) begin errors++; $display("FAIL setwin_pop_r4: got %0d want 4", Write_Register_Port); end
    step();
    MD_Issue = 0; settle();
    checks++; if (Stall_ID !== 1'b1) begin errors++; $display("FAIL setwin_stall: got %b want 1", Stall_ID); end
    MD_Valid = 1; MD_Data = 32'h45; step();
    MD_Valid = 0; step();
    checks++; if (Stall_ID !== 1'b0) begin errors++; $display("FAIL setwin_clear: got %b want 0", Stall_ID); end
  endtask

  initial begin
    idle(); Reset = 1;
    test_reset();
    test_md_basic();
    test_starve();
    test_wb_r0();
    test_forward();
    test_set_wins();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
